// File: rtl/lsu_dmem_ctrl_if.sv
// Request/response and data-memory signals of the RV32I load/store initiator.
// The master side issues requests and models the memory; the slave side is the controller.
interface lsu_dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_wdata, dmem_we
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_wdata, dmem_we
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// RV32I load/store initiator for a byte-write-enable, synchronous-read data memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses report rsp_err.
module lsu_dmem_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    lsu_dmem_ctrl_if.slave       bus
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               cnt_last;

    logic               accept;
    logic               f3_legal;
    logic               misalign;
    logic               req_ok;

    logic               we_p0;
    logic               err_p0;
    logic [2:0]         funct3_p0;
    logic [31:0]        addr_p0;
    logic [31:0]        wdata_p0;
    logic [31:0]        rdata_p1;

    logic               req_ready;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [31:0]        dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [3:0]         dmem_we;

    function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Sign extension goes through signed temporaries so the widening is explicit.
    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic        [31:0] shifted;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] ext_s;
        shifted = rd >> {a, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  begin ext_s = byte_s; return ext_s; end
            3'b001:  begin ext_s = half_s; return ext_s; end
            3'b100:  return {24'd0, byte_s};
            3'b101:  return {16'd0, half_s};
            default: return rd;
        endcase
    endfunction

    assign accept = bus.req_valid && (state_q == IDLE);

    always_comb begin
        if (bus.req_we) f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        else            f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b01:   misalign = bus.req_addr[0];
            2'b10:   misalign = |bus.req_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign req_ok   = f3_legal && !misalign;
    assign cnt_last = (cnt_q == CNT_W'(RD_LAT - 1));

    // Stage p0: request capture on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0     <= bus.req_we;
            err_p0    <= !req_ok;
            funct3_p0 <= bus.req_funct3;
            addr_p0   <= bus.req_addr;
            wdata_p0  <= bus.req_wdata;
        end
    end

    // Stage p1: aligned/extended load result sampled on the last wait cycle
    always_ff @(posedge clk) begin
        if (state_q == WAIT && cnt_last)
            rdata_p1 <= load_extract(bus.dmem_rdata, funct3_p0, addr_p0[1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_ok ? ACCESS : RESP;
            ACCESS:  state_d = we_p0 ? RESP : WAIT;
            WAIT:    if (cnt_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from state so a reset clears them without extra data resets.
    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = '0;
        case (state_q)
            IDLE:   req_ready = 1'b1;
            ACCESS: begin
                dmem_addr = {addr_p0[31:2], 2'b00};
                if (we_p0) begin
                    dmem_we    = store_lanes(funct3_p0[1:0], addr_p0[1:0]);
                    dmem_wdata = store_data(funct3_p0[1:0], wdata_p0);
                end
            end
            WAIT:   dmem_addr = {addr_p0[31:2], 2'b00};
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_p0;
                rsp_rdata = (err_p0 || we_p0) ? 32'd0 : rdata_p1;
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_rdata  = rsp_rdata;
    assign bus.rsp_err    = rsp_err;
    assign bus.dmem_addr  = dmem_addr;
    assign bus.dmem_wdata = dmem_wdata;
    assign bus.dmem_we    = dmem_we;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: directed requests, a byte-lane memory model, and a
// per-cycle comparison against a transaction-level reference model.
module tb_lsu_dmem_ctrl;

    localparam int RD_LAT = 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lsu_dmem_ctrl_if bus();

    lsu_dmem_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT
    bit   [31:0] mem [64];
    logic [31:0] rd_pipe [RD_LAT];
    logic [31:0] wr_w;

    always @(posedge clk) begin
        wr_w = mem[bus.dmem_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (bus.dmem_we[b]) wr_w[8*b +: 8] = bus.dmem_wdata[8*b +: 8];
        mem[bus.dmem_addr[7:2]] <= wr_w;
        rd_pipe[0] <= mem[bus.dmem_addr[7:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.dmem_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, described by its latency and results
    bit [31:0] ref_mem [64];
    bit        pending;
    int        off;
    bit        m_we, m_legal, m_err;
    int        m_lat;
    bit [31:0] m_word, m_wdata, m_rdata;
    bit [3:0]  m_lanes;

    task automatic model_accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd);
        int     size;
        int     base;
        bit     legal;
        longint v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef MISALIGN_TRAP_EN
        if ((int'(a[1:0]) % size) != 0) legal = 1'b0;
`endif
        base    = (int'(a[1:0]) / size) * size;
        m_word  = {a[31:2], 2'b00};
        m_we    = we;
        m_legal = legal;
        m_err   = !legal;
        m_lat   = !legal ? 1 : (we ? 2 : 2 + RD_LAT);
        m_lanes = '0;
        m_wdata = '0;
        m_rdata = '0;
        if (legal && we) begin
            for (int b = 0; b < 4; b++) begin
                m_wdata[8*b +: 8] = wd[8*(b % size) +: 8];
                if (b >= base && b < base + size) begin
                    m_lanes[b] = 1'b1;
                    ref_mem[a[7:2]][8*b +: 8] = wd[8*(b % size) +: 8];
                end
            end
        end else if (legal) begin
            v = longint'(ref_mem[a[7:2]] >> (8 * base)) & ((64'd1 << (8 * size)) - 64'd1);
            if (!f3[2] && size < 4 && v >= longint'(64'd1 << (8 * size - 1)))
                v = v - longint'(64'd1 << (8 * size));
            m_rdata = v[31:0];
        end
    endtask

    always @(negedge clk) begin
        bit        e_ready, e_valid, e_err;
        bit [31:0] e_rdata, e_addr, e_wdata;
        bit [3:0]  e_we;
        if (reset) begin
            pending = 1'b0;
            e_ready = 1'b1; e_valid = 1'b0; e_err = 1'b0;
            e_rdata = '0;   e_addr = '0;    e_wdata = '0; e_we = '0;
        end else begin
            if (pending) off++;
            e_ready = !pending;
            e_valid = pending && off == m_lat;
            e_err   = e_valid && m_err;
            e_rdata = e_valid ? m_rdata : 32'd0;
            e_addr  = (pending && m_legal && off >= 1 && off <= (m_we ? 1 : 1 + RD_LAT))
                      ? m_word : 32'd0;
            e_we    = (pending && m_legal && m_we && off == 1) ? m_lanes : 4'd0;
            e_wdata = (pending && m_legal && m_we && off == 1) ? m_wdata : 32'd0;
        end
        chk("cyc_req_ready",  32'(bus.req_ready),  32'(e_ready));
        chk("cyc_rsp_valid",  32'(bus.rsp_valid),  32'(e_valid));
        chk("cyc_rsp_err",    32'(bus.rsp_err),    32'(e_err));
        chk("cyc_rsp_rdata",  bus.rsp_rdata,       e_rdata);
        chk("cyc_dmem_addr",  bus.dmem_addr,       e_addr);
        chk("cyc_dmem_we",    32'(bus.dmem_we),    32'(e_we));
        chk("cyc_dmem_wdata", bus.dmem_wdata,      e_wdata);
        if (!reset) begin
            if (e_valid) pending = 1'b0;
            if (e_ready && bus.req_valid) begin
                pending = 1'b1;
                off     = 0;
                model_accept(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata);
            end
        end
    end

    // Issue one request; report latency, response and the dmem signals of the first cycle
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                          output logic err, output logic [3:0] acc_we,
                          output logic [31:0] acc_addr, output logic [31:0] acc_wdata);
        int n;
        bit got;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL req_accept_timeout: req_ready stuck at 0");
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; rdata = '0; err = 1'b0; got = 1'b0;
        acc_we = '0; acc_addr = '0; acc_wdata = '0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                acc_we    = bus.dmem_we;
                acc_addr  = bus.dmem_addr;
                acc_wdata = bus.dmem_wdata;
            end
            if (bus.rsp_valid) begin
                got = 1'b1; lat = k; rdata = bus.rsp_rdata; err = bus.rsp_err;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 20 cycles, expected one");
        end
    endtask

    int          lat;
    logic [31:0] rdata, acc_addr, acc_wdata;
    logic        err;
    logic [3:0]  acc_we;
    bit          saw_rsp;

    initial begin
        checks = 0; errors = 0; pending = 1'b0; off = 0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready",  32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("reset_dmem_we",    32'(bus.dmem_we),   32'd0);
        chk("reset_dmem_addr",  bus.dmem_addr,      32'd0);
        reset = 1'b0;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("sw_addr",  acc_addr,    32'h10);
        chk("sw_we",    32'(acc_we), 32'hF);
        chk("sw_wdata", acc_wdata,   32'hDEADBEEF);
        chk("sw_lat",   32'(lat),    32'd2);
        chk("sw_err",   32'(err),    32'd0);

        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("sb_we",    32'(acc_we), 32'h8);
        chk("sb_wdata", acc_wdata,   32'hA5A5A5A5);
        chk("sb_lat",   32'(lat),    32'd2);

        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("lw_rdata", rdata,    32'hA5ADBEEF);
        chk("lw_lat",   32'(lat), 32'd3);
        chk("lw_we",    32'(acc_we), 32'd0);

        do_req(1'b1, 3'b010, 32'h10, 32'h80000000, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("lbu_rdata", rdata, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("lh_rdata", rdata, 32'hFFFF8000);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("lhu_rdata", rdata, 32'h00008000);

        do_req(1'b1, 3'b001, 32'h16, 32'h0000BEEF, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("sh_addr",  acc_addr,    32'h14);
        chk("sh_we",    32'(acc_we), 32'hC);
        chk("sh_wdata", acc_wdata,   32'hBEEFBEEF);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("sh_readback", rdata, 32'hBEEF0000);

        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("ill_ld_err",   32'(err),    32'd1);
        chk("ill_ld_rdata", rdata,       32'd0);
        chk("ill_ld_lat",   32'(lat),    32'd1);
        chk("ill_ld_addr",  acc_addr,    32'd0);
        do_req(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("ill_st_err", 32'(err),    32'd1);
        chk("ill_st_we",  32'(acc_we), 32'd0);
        do_req(1'b0, 3'b110, 32'h10, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("ill_ld110_err", 32'(err), 32'd1);

        do_req(1'b0, 3'b010, 32'h11, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
`ifdef MISALIGN_TRAP_EN
        chk("lw_mis_err", 32'(err), 32'd1);
        chk("lw_mis_lat", 32'(lat), 32'd1);
`else
        chk("lw_mis_rdata", rdata,    32'h80000000);
        chk("lw_mis_lat",   32'(lat), 32'd3);
        chk("lw_mis_err",   32'(err), 32'd0);
`endif

        // Reset while the load is waiting on the memory
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wait_dmem_addr", bus.dmem_addr, 32'h10);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_addr",  bus.dmem_addr,      32'd0);
        chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_rdata", bus.rsp_rdata,      32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        saw_rsp = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        chk("rst_no_rsp",      32'(saw_rsp),       32'd0);
        chk("rst_ready_after", 32'(bus.req_ready), 32'd1);

        do_req(1'b1, 3'b010, 32'h20, 32'h12345678, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("post_rst_sw_lat", 32'(lat), 32'd2);
        chk("post_rst_sw_err", 32'(err), 32'd0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rdata, err, acc_we, acc_addr, acc_wdata);
        chk("post_rst_lw", rdata, 32'h12345678);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
